// File: rtl/cpu_pkg.sv
// Types and default widths shared by the program loader, the RAM and the CPU.
package cpu_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WRITE  = 3'd1,
    S_VERIFY = 3'd2,
    S_DONE   = 3'd3,
    S_ERROR  = 3'd4
  } loader_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_OVERFLOW = 2'd1,
    ERR_CHECKSUM = 2'd2,
    ERR_EMPTY    = 2'd3
  } err_code_e;

endpackage

// File: rtl/loader_checksum.sv
// Modular byte accumulator with synchronous clear and an equality compare
// against a reference sum. Used for both the write-side and readback sums.
module loader_checksum
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] ref_sum,
  output logic [DATA_W-1:0] sum,
  output logic              match
);

  // Running sum; clear wins over accumulate so a new load never inherits a stale value.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: registers are written with <= so every flop samples pre-edge values.
    if (reset)       sum <= '0;
    else if (clear)  sum <= '0;
    else if (acc_en) sum <= sum + data_in; // wraps mod 2**DATA_W
  end

  assign match = (sum == ref_sum);

endmodule

// File: rtl/program_loader.sv
// Writes a valid/ready byte stream into RAM from address 0 upward, optionally
// reads it back to confirm the checksum, and raises cpu_run on a good image.
module program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MEM_DEPTH = 256,
  parameter int VERIFY    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_save,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_value,
  output logic              bus_own,
  output logic              cpu_run,
  output logic              busy,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  loader_state_e       state;
  err_code_e           err_q;
  logic [ADDR_W-1:0]   ptr;       // next write address
  logic [ADDR_W:0]     vptr;      // readback addresses issued so far
  logic                rd_valid;  // ram_value holds data for a read issued last cycle
  logic                accept;
  logic                restart;
  logic                wr_match;
  logic                rd_match;
  logic                sums_equal;
  logic [DATA_W-1:0]   shadow;

  // NOTE: in_ready is a pure continuous decode of state, so no latch can form.
  assign in_ready = (state == S_WRITE);
  assign accept   = in_valid & in_ready;
  assign restart  = start & ((state == S_IDLE) | (state == S_DONE) | (state == S_ERROR));
  assign err_code = err_q;

  // Each instance compares its own sum with the other's; both flags say the same thing.
  assign sums_equal = wr_match & rd_match;

  loader_checksum #(.DATA_W(DATA_W)) u_wr_sum (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .acc_en  (accept),
    .data_in (in_data),
    .ref_sum (shadow),
    .sum     (checksum),
    .match   (wr_match)
  );

  loader_checksum #(.DATA_W(DATA_W)) u_rd_sum (
    .clk     (clk),
    .reset   (reset),
    .clear   (restart),
    .acc_en  (rd_valid),
    .data_in (ram_value),
    .ref_sum (checksum),
    .sum     (shadow),
    .match   (rd_match)
  );

  // Loader FSM with all RAM-side and status outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      err_q    <= ERR_NONE;
      ptr      <= '0;
      vptr     <= '0;
      rd_valid <= 1'b0;
      count    <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_save <= 1'b0;
      ram_load <= 1'b0;
      bus_own  <= 1'b0;
      cpu_run  <= 1'b0;
      busy     <= 1'b0;
      error    <= 1'b0;
    end else begin
      // NOTE: strobes default low here so they are one-cycle pulses unless re-asserted below.
      ram_save <= 1'b0;
      ram_load <= 1'b0;
      rd_valid <= ram_load;

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          // bus_own may still be high for one cycle after WRITE while the final byte lands.
          bus_own <= 1'b0;
          if (start) begin
            state   <= S_WRITE;
            err_q   <= ERR_NONE;
            ptr     <= '0;
            vptr    <= '0;
            count   <= '0;
            error   <= 1'b0;
            cpu_run <= 1'b0;
            busy    <= 1'b1;
            bus_own <= 1'b1;
          end
        end

        S_WRITE: begin
          if (accept) begin
            ram_save <= 1'b1;
            ram_addr <= ptr;
            ram_data <= in_data;
            ptr      <= ptr + PTR_ONE;
            count    <= count + CNT_ONE;
            if (in_last) begin
              if (VERIFY != 0) begin
                state <= S_VERIFY;
              end else begin
                state   <= S_DONE;
                busy    <= 1'b0;
                cpu_run <= 1'b1;
              end
            end else if (ptr == LAST_PTR) begin
              state <= S_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
              err_q <= ERR_OVERFLOW;
            end
          end
        end

        S_VERIFY: begin
          if (vptr != count) begin
            ram_load <= 1'b1;
            ram_addr <= vptr[ADDR_W-1:0];
            vptr     <= vptr + CNT_ONE;
          end else if (!ram_load && !rd_valid) begin
            // All reads issued and returned; shadow is final in this compare cycle.
            busy    <= 1'b0;
            bus_own <= 1'b0;
            if (sums_equal) begin
              state   <= S_DONE;
              cpu_run <= 1'b1;
            end else begin
              state <= S_ERROR;
              error <= 1'b1;
              err_q <= ERR_CHECKSUM;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the stimulus side pushes expected RAM
// writes and load results, a negedge monitor pops and compares them.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_save;
  logic       ram_load;
  logic [7:0] ram_value;
  logic       bus_own;
  logic       cpu_run;
  logic       busy;
  logic       error;
  logic [1:0] err_code;
  logic [8:0] count;
  logic [7:0] checksum;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic       error;
    logic [1:0] code;
    logic [8:0] count;
    logic [7:0] sum;
    logic       run;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  wr_t  w;
  res_t r;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   exp_ptr  = 0;
  logic prev_busy = 1'b0;
  logic corrupt   = 1'b0;
  logic [7:0] mem [256];

  program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_save  (ram_save),
    .ram_load  (ram_load),
    .ram_value (ram_value),
    .bus_own   (bus_own),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .error     (error),
    .err_code  (err_code),
    .count     (count),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model; optional single-bit corruption of address 1 on readback.
  always @(posedge clk) begin
    if (ram_save) mem[ram_addr] <= ram_data;
    if (ram_load) ram_value <= mem[ram_addr] ^ ((corrupt && ram_addr == 8'd1) ? 8'h01 : 8'h00);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares RAM writes and end-of-load status against the queued expectations.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (ram_save) begin
        if (wr_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL wr_extra: ram_save addr 0x%0h data 0x%0h, none expected", ram_addr, ram_data);
        end else begin
          w = wr_q.pop_front();
          check("wr_addr", 32'(ram_addr), 32'(w.addr));
          check("wr_data", 32'(ram_data), 32'(w.data));
          check("wr_bus_own", 32'(bus_own), 32'd1);
        end
      end
      if (prev_busy && !busy) begin
        if (res_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("FAIL res_extra: load ended with err_code %0d, none expected", err_code);
        end else begin
          r = res_q.pop_front();
          check("res_error", 32'(error), 32'(r.error));
          check("res_code", 32'(err_code), 32'(r.code));
          check("res_count", 32'(count), 32'(r.count));
          check("res_checksum", 32'(checksum), 32'(r.sum));
          check("res_cpu_run", 32'(cpu_run), 32'(r.run));
        end
      end
      prev_busy = busy;
    end
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input bit push);
    bit taken = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    if (push) wr_q.push_back('{addr: 8'(exp_ptr), data: d});
    exp_ptr++;
    for (int i = 0; i < 16 && !taken; i++) begin
      taken = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!taken) begin
      n_checks++;
      n_fails++;
      $display("FAIL send_timeout: byte 0x%0h never accepted, in_ready %0d", d, in_ready);
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 2000 && !idle; i++) begin
      if (!busy) idle = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!idle) begin
      n_checks++;
      n_fails++;
      $display("FAIL busy_timeout: busy still %0d after budget", busy);
    end
    @(negedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    in_last  = 1'b0;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_ram_save", 32'(ram_save), 32'd0);
    check("rst_ram_load", 32'(ram_load), 32'd0);
    check("rst_bus_own", 32'(bus_own), 32'd0);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Three bytes with readback; start pulses during WRITE and VERIFY are ignored.
    res_q.push_back('{error: 1'b0, code: 2'd0, count: 9'd3, sum: 8'h66, run: 1'b1});
    do_start();
    check("a_busy", 32'(busy), 32'd1);
    check("a_in_ready", 32'(in_ready), 32'd1);
    send(8'h11, 1'b0, 1'b1);
    start = 1'b1;
    send(8'h22, 1'b0, 1'b1);
    start = 1'b0;
    check("a_start_in_write_count", 32'(count), 32'd2);
    send(8'h33, 1'b1, 1'b1);
    check("a_in_ready_after_last", 32'(in_ready), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("a_start_in_verify_busy", 32'(busy), 32'd1);
    check("a_start_in_verify_count", 32'(count), 32'd3);
    wait_idle();
    check("a_cpu_run", 32'(cpu_run), 32'd1);
    check("a_bus_own", 32'(bus_own), 32'd0);

    // Start from DONE drops cpu_run at once; then a full 256-byte image with last.
    res_q.push_back('{error: 1'b0, code: 2'd0, count: 9'd256, sum: 8'h80, run: 1'b1});
    do_start();
    check("b_cpu_run_drop", 32'(cpu_run), 32'd0);
    check("b_busy", 32'(busy), 32'd1);
    check("b_count_clear", 32'(count), 32'd0);
    check("b_checksum_clear", 32'(checksum), 32'd0);
    for (int i = 0; i < 256; i++) send(8'(i), (i == 255), 1'b1);
    wait_idle();

    // 256 bytes with no last: every byte lands, then overflow.
    res_q.push_back('{error: 1'b1, code: 2'd1, count: 9'd256, sum: 8'h80, run: 1'b0});
    do_start();
    for (int i = 0; i < 256; i++) send(8'(i), 1'b0, 1'b1);
    wait_idle();
    check("c_in_ready", 32'(in_ready), 32'd0);
    check("c_error_sticky", 32'(error), 32'd1);

    // Readback corruption at address 1 gives a checksum error.
    corrupt = 1'b1;
    res_q.push_back('{error: 1'b1, code: 2'd2, count: 9'd3, sum: 8'h66, run: 1'b0});
    do_start();
    check("d_error_cleared", 32'(error), 32'd0);
    send(8'h11, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b1);
    send(8'h33, 1'b1, 1'b1);
    wait_idle();
    corrupt = 1'b0;
    check("d_cpu_run", 32'(cpu_run), 32'd0);

    // Gapped stream: exactly two writes, checksum wraps to zero.
    res_q.push_back('{error: 1'b0, code: 2'd0, count: 9'd2, sum: 8'h00, run: 1'b1});
    do_start();
    send(8'hFF, 1'b0, 1'b1);
    @(posedge clk); #1;
    send(8'h01, 1'b1, 1'b1);
    wait_idle();

    // Asynchronous reset while the second byte's write strobe is high.
    do_start();
    send(8'hA1, 1'b0, 1'b1);
    send(8'hB2, 1'b0, 1'b0);
    check("f_save_before_reset", 32'(ram_save), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("f_rst_ram_save", 32'(ram_save), 32'd0);
    check("f_rst_busy", 32'(busy), 32'd0);
    check("f_rst_count", 32'(count), 32'd0);
    check("f_rst_bus_own", 32'(bus_own), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    res_q.push_back('{error: 1'b0, code: 2'd0, count: 9'd1, sum: 8'h5A, run: 1'b1});
    do_start();
    send(8'h5A, 1'b1, 1'b1);
    wait_idle();
    check("f_mem0", 32'(mem[0]), 32'h5A);

    repeat (3) @(posedge clk);
    #1;
    check("wr_q_drained", 32'(wr_q.size()), 32'd0);
    check("res_q_drained", 32'(res_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
